// File: rtl/clock_generator_pkg.sv
// rtl/clock_generator_pkg.sv - mode encoding and reset defaults for the divided clock
package clock_generator_pkg;

   typedef enum logic [1:0] {
      MODE_FAST = 2'd0,
      MODE_SLOW = 2'd1,
      MODE_STEP = 2'd2,
      MODE_HALT = 2'd3
   } mode_t;

   localparam int CLKGEN_DEFAULT_DIVISOR = 2;

endpackage

// File: rtl/rising_edge_detector.sv
// rtl/rising_edge_detector.sv - one-cycle strobe on a 0->1 transition of a level input
module rising_edge_detector (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_level,
   output logic o_pulse
);

   logic r_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= i_level;
      end
   end

   assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/clock_generator.sv
// rtl/clock_generator.sv - programmable divided clock with FAST/SLOW/STEP/HALT modes
module clock_generator
   import clock_generator_pkg::*;
#(
   parameter int DIV_WIDTH       = 8,
   parameter int SLOW_SHIFT      = 17,
   parameter int DEFAULT_DIVISOR = CLKGEN_DEFAULT_DIVISOR
) (
   input  logic                 clock_100mhz,
   input  logic                 reset,
   input  logic [1:0]           mode,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic                 divisor_load,
   input  logic                 step_request,
   output logic                 clock_divided,
   output logic                 rise_pulse,
   output logic                 fall_pulse,
   output logic                 step_done,
   output logic [1:0]           active_mode
);

   localparam int CNT_WIDTH = DIV_WIDTH + SLOW_SHIFT;

   mode_t                r_pending_mode;
   mode_t                r_active_mode;
   logic [DIV_WIDTH-1:0] r_pending_div;
   logic [DIV_WIDTH-1:0] r_active_div;
   logic [CNT_WIDTH-1:0] r_counter;
   logic                 r_clk;
   logic                 r_rise;
   logic                 r_fall;
   logic                 r_step_done;

   logic                 w_step_edge;
   logic [DIV_WIDTH-1:0] w_div_eff;
   logic [CNT_WIDTH-1:0] w_limit_base;
   logic [CNT_WIDTH-1:0] w_limit;
   logic [CNT_WIDTH-1:0] w_last;
   logic [CNT_WIDTH-1:0] w_nxt_cnt;
   logic                 w_nxt_clk;
   logic                 w_commit;

   rising_edge_detector u_step_edge (
      .i_clk   (clock_100mhz),
      .i_rst   (reset),
      .i_level (step_request),
      .o_pulse (w_step_edge)
   );

   assign w_div_eff    = (r_active_div == '0) ? DIV_WIDTH'(1) : r_active_div;
   assign w_limit_base = CNT_WIDTH'(w_div_eff);
   assign w_limit      = (r_active_mode == MODE_SLOW) ? (w_limit_base << SLOW_SHIFT) : w_limit_base;
   assign w_last       = w_limit - CNT_WIDTH'(1);

   // Idle states (HALT, STEP with output low) commit every cycle so a new mode lands at once.
   always_comb begin
      w_nxt_clk = r_clk;
      w_nxt_cnt = r_counter;
      w_commit  = 1'b0;
      if (r_active_mode == MODE_HALT) begin
         w_nxt_clk = 1'b0;
         w_nxt_cnt = '0;
         w_commit  = 1'b1;
      end else if ((r_active_mode == MODE_STEP) && !r_clk) begin
         w_nxt_cnt = '0;
         if (w_step_edge) begin
            w_nxt_clk = 1'b1;
         end else begin
            w_commit = 1'b1;
         end
      end else if (r_counter == w_last) begin
         w_nxt_cnt = '0;
         w_nxt_clk = ~r_clk;
         w_commit  = r_clk;
      end else begin
         w_nxt_cnt = r_counter + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock_100mhz or posedge reset) begin
      if (reset) begin
         r_pending_mode <= MODE_FAST;
         r_active_mode  <= MODE_FAST;
         r_pending_div  <= DIV_WIDTH'(DEFAULT_DIVISOR);
         r_active_div   <= DIV_WIDTH'(DEFAULT_DIVISOR);
         r_counter      <= '0;
         r_clk          <= 1'b0;
         r_rise         <= 1'b0;
         r_fall         <= 1'b0;
         r_step_done    <= 1'b0;
      end else begin
         r_pending_mode <= mode_t'(mode);
         if (divisor_load) begin
            r_pending_div <= divisor;
         end
         // Commit reads the registered pending values, so a same-cycle load waits a boundary.
         if (w_commit) begin
            r_active_mode <= r_pending_mode;
            r_active_div  <= r_pending_div;
         end
         r_counter   <= w_nxt_cnt;
         r_clk       <= w_nxt_clk;
         r_rise      <= w_nxt_clk & ~r_clk;
         r_fall      <= ~w_nxt_clk & r_clk;
         r_step_done <= (r_active_mode == MODE_STEP) & r_clk & ~w_nxt_clk;
      end
   end

   assign clock_divided = r_clk;
   assign rise_pulse    = r_rise;
   assign fall_pulse    = r_fall;
   assign step_done     = r_step_done;
   assign active_mode   = r_active_mode;

endmodule

// File: tb/tb_clock_generator.sv
// tb/tb_clock_generator.sv - directed self-checking bench for clock_generator
module tb_clock_generator;

   logic       clock_100mhz = 1'b0;
   logic       reset        = 1'b1;
   logic [1:0] mode         = 2'd0;
   logic [7:0] divisor      = 8'd0;
   logic       divisor_load = 1'b0;
   logic       step_request = 1'b0;
   logic       clock_divided;
   logic       rise_pulse;
   logic       fall_pulse;
   logic       step_done;
   logic [1:0] active_mode;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] tr_clk;
   logic [31:0] tr_rise;
   logic [31:0] tr_fall;
   logic [31:0] tr_done;

   clock_generator #(
      .DIV_WIDTH       (8),
      .SLOW_SHIFT      (2),
      .DEFAULT_DIVISOR (2)
   ) dut (
      .clock_100mhz  (clock_100mhz),
      .reset         (reset),
      .mode          (mode),
      .divisor       (divisor),
      .divisor_load  (divisor_load),
      .step_request  (step_request),
      .clock_divided (clock_divided),
      .rise_pulse    (rise_pulse),
      .fall_pulse    (fall_pulse),
      .step_done     (step_done),
      .active_mode   (active_mode)
   );

   always #5 clock_100mhz = ~clock_100mhz;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic clear_trace();
      tr_clk  = '0;
      tr_rise = '0;
      tr_fall = '0;
      tr_done = '0;
   endtask

   // Each cycle: one rising edge, then sample on the falling edge; oldest cycle ends up MSB.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock_100mhz);
         @(negedge clock_100mhz);
         tr_clk  = {tr_clk[30:0], clock_divided};
         tr_rise = {tr_rise[30:0], rise_pulse};
         tr_fall = {tr_fall[30:0], fall_pulse};
         tr_done = {tr_done[30:0], step_done};
      end
   endtask

   task automatic restart();
      @(negedge clock_100mhz);
      reset = 1'b1;
      @(negedge clock_100mhz);
      reset = 1'b0;
      clear_trace();
   endtask

   initial begin
      // reset state
      @(negedge clock_100mhz);
      @(negedge clock_100mhz);
      check("rst_clk", 32'(clock_divided), 32'd0);
      check("rst_rise", 32'(rise_pulse), 32'd0);
      check("rst_fall", 32'(fall_pulse), 32'd0);
      check("rst_done", 32'(step_done), 32'd0);
      check("rst_mode", 32'(active_mode), 32'd0);

      // default divisor 2 in FAST
      reset = 1'b0;
      clear_trace();
      run(8);
      check("fast_clk", tr_clk, 32'b0110_0110);
      check("fast_rise", tr_rise, 32'b0100_0100);
      check("fast_fall", tr_fall, 32'b0001_0001);

      // div 3, then load 5 during a high phase
      mode = 2'd0; divisor = 8'd3; divisor_load = 1'b1;
      restart();
      run(1);
      divisor_load = 1'b0;
      run(6);
      divisor = 8'd5; divisor_load = 1'b1;
      run(1);
      divisor_load = 1'b0;
      run(12);
      check("load_clk", tr_clk, 32'b0110_0011_1000_0011_1110);
      check("load_rise", tr_rise, 32'b0100_0010_0000_0010_0000);
      check("load_fall", tr_fall, 32'b0001_0000_0100_0000_0001);

      // SLOW with shift 2, div 1; then async reset while high
      mode = 2'd1; divisor = 8'd1; divisor_load = 1'b1;
      restart();
      run(1);
      divisor_load = 1'b0;
      run(2);
      check("slow_mode_pre", 32'(active_mode), 32'd0);
      run(1);
      check("slow_mode_post", 32'(active_mode), 32'd1);
      run(13);
      check("slow_clk", tr_clk, 32'b0110_0001_1110_0001_1);
      reset = 1'b1;
      #1;
      check("arst_clk", 32'(clock_divided), 32'd0);
      check("arst_mode", 32'(active_mode), 32'd0);
      check("arst_rise", 32'(rise_pulse), 32'd0);

      // HALT requested one cycle into a 4-cycle high phase, then leave HALT
      mode = 2'd0; divisor = 8'd4; divisor_load = 1'b1;
      restart();
      run(1);
      divisor_load = 1'b0;
      run(7);
      mode = 2'd3;
      run(3);
      check("halt_mode_high", 32'(active_mode), 32'd0);
      run(1);
      check("halt_mode_fall", 32'(active_mode), 32'd3);
      run(6);
      check("halt_clk", tr_clk, 32'b0110_0001_1110_0000_00);
      clear_trace();
      mode = 2'd0;
      run(1);
      check("unhalt_mode_lag", 32'(active_mode), 32'd3);
      run(1);
      check("unhalt_mode", 32'(active_mode), 32'd0);
      run(4);
      check("unhalt_clk", tr_clk, 32'b000001);

      // STEP with div 3; edge in FAST ignored, held level gives one pulse, edge while high ignored
      mode = 2'd2; divisor = 8'd3; divisor_load = 1'b1; step_request = 1'b0;
      restart();
      run(1);
      divisor_load = 1'b0; step_request = 1'b1;
      run(1);
      step_request = 1'b0;
      run(4);
      step_request = 1'b1;
      run(10);
      step_request = 1'b0;
      run(1);
      step_request = 1'b1;
      run(1);
      step_request = 1'b0;
      run(1);
      step_request = 1'b1;
      run(5);
      check("step_clk", tr_clk, 32'b0110_0011_1000_0000_0111_0000);
      check("step_done", tr_done, 32'b0000_0000_0100_0000_0000_1000);
      step_request = 1'b0;

      // divisor 0 acts as 1
      mode = 2'd0; divisor = 8'd0; divisor_load = 1'b1;
      restart();
      run(1);
      divisor_load = 1'b0;
      run(9);
      check("div0_clk", tr_clk, 32'b0110_1010_10);
      check("div0_rise", tr_rise, 32'b0100_1010_10);
      check("div0_fall", tr_fall, 32'b0001_0101_01);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
